muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It replaces the combinational mult/div path in the execute stage.
- Accepts one operation at a time from decode/execute (mult, multu, div, divu, mthi, mtlo).
- Multiply uses a registered product with a fixed latency. Divide uses an iterative radix-2 restoring divider.
- Drives busy so the control unit stalls any mf/mt/muldiv instruction issued while an operation is in flight.

Parameters:
- MUL_CYCLES, 2, cycles busy for mult/multu (legal range 1-8).
- DIV_ITERS, 32, divider iterations (one quotient bit per cycle); fixed to data width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request strobe; sampled only in IDLE
- Function_opcode  in  6  instruction[5:0]: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x11 mthi, 0x13 mtlo
- Ainput  in  32  rs operand (dividend/multiplicand; mthi/mtlo source)
- Binput  in  32  rt operand (divisor/multiplier)
- busy  out  1  operation in flight; control must stall
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, all internal counters/regs 0. Reset mid-operation aborts the operation; HI/LO become 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start:
  - mthi: hi<=Ainput at that edge, no busy.
  - mtlo: lo<=Ainput at that edge, no busy.
  - mult/multu: latch operands, go MUL.
  - div/divu: go DIV, or go FIX directly when a special case applies.
  - Unknown funct: ignored.
- start while not IDLE: ignored; no queueing, no error flag.
- MUL:
  - Counter runs 1..MUL_CYCLES; exit to DONE after MUL_CYCLES cycles.
  - At the exiting edge, {hi,lo}<=64-bit product: signed for 0x18, unsigned for 0x19.
  - Operand registers hold values; Ainput/Binput may change after the start cycle.
- DIV:
  - Signed ops (0x1A) convert operands to magnitudes and record quotient sign = sign(A) xor sign(B) and remainder sign = sign(A).
  - DIV_ITERS iterations, one per cycle, restoring shift-subtract on 32-bit magnitudes; then FIX.
- FIX (one cycle):
  - Apply the recorded signs and write lo<=quotient, hi<=remainder.
  - Special cases, entered directly from IDLE and resolved here:
    - B==0: lo=0xFFFFFFFF, hi=Ainput.
    - Signed A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Remainder sign always follows dividend (truncating division).
- DONE: one cycle, done=1, busy=0, then IDLE. A start in DONE is ignored; control releases the stall at DONE, so the next issue lands in IDLE.
- busy=1 in MUL, DIV, FIX; 0 in IDLE, DONE.
- Start sampled at edge k gives:
  - mult: busy cycles k+1..k+MUL_CYCLES, done at cycle k+MUL_CYCLES+1.
  - div (normal): busy cycles k+1..k+33, done at k+34.
  - div (special case): busy cycle k+1 only, done at k+2.
- HI/LO change only at mthi/mtlo edges, MUL exit, or FIX. They hold otherwise, including during busy.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 in MUL/DIV/FIX returns to IDLE at the next edge with HI/LO unchanged and no done pulse.
  - cancel in IDLE/DONE has no effect.
  - cancel together with start in IDLE: start wins.
- Undefined: no port; operations always complete.

Decomposition:
- Package muldiv_pkg holds:
  - State enum.
  - Funct constants FUNCT_MULT/MULTU/DIV/DIVU/MTHI/MTLO.
  - DIV_BY_ZERO_LO = 0xFFFFFFFF.
  - DIV_ITERS.
- Sub-module div_iter_core: magnitude restoring divider, one iteration per cycle. Ports clock, reset, load, dividend, divisor, quotient, remainder, last. The sequencer owns sign handling and FIX.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, MUL_CYCLES=2 -> busy 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 33 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with the same operands -> lo=0x7FFFFFFC, hi=1.
- divu A=5, B=0 -> busy 1 cycle; lo=0xFFFFFFFF, hi=5. div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x1234 then mtlo 0xABCD in consecutive IDLE cycles -> hi=0x1234, lo=0xABCD, busy never set. A second start during div busy -> ignored, result unchanged.
- reset asserted at iteration 10 of a div -> next cycle IDLE, hi=lo=0, busy=0, no done. With MULDIV_CANCEL_EN: cancel at iteration 10 -> HI/LO keep prior values, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);
  localparam int unsigned MCNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN        = 32'h8000_0000;

  // Magnitude of v when treated as signed, else v unchanged.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned radix-2 restoring divider: load, then one quotient bit per cycle.
module div_iter_core
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             last_q, last_d;
  logic [XLEN:0]    trial;

  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    // Shifted partial remainder minus divisor; bit XLEN set means it did not fit.
    trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (load) begin
      quo_d    = dividend;
      rem_d    = '0;
      dvs_d    = divisor;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (last_q) active_d = 1'b0;
    end
    last_d = active_d && (cnt_d == CNT_W'(DIV_ITERS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      last_q   <= last_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = last_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO.
// Optional MULDIV_CANCEL_EN adds a cancel input that aborts an in-flight op.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      Function_opcode,
  input  logic [XLEN-1:0] Ainput,
  input  logic [XLEN-1:0] Binput,
`ifdef MULDIV_CANCEL_EN
  input  logic            cancel,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              special_q, special_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              load_c, cancel_c, div_special_c, op_signed_c;
  logic [2*XLEN-1:0] a_ext, b_ext, prod_c;
  logic [XLEN-1:0]   div_quo, div_rem, q_fix, r_fix;
  logic              div_last;

`ifdef MULDIV_CANCEL_EN
  assign cancel_c = cancel;
`else
  assign cancel_c = 1'b0;
`endif

  div_iter_core u_div (
    .clock    (clock),
    .reset    (reset),
    .load     (load_c),
    .dividend (mag(Ainput, op_signed_c)),
    .divisor  (mag(Binput, op_signed_c)),
    .quotient (div_quo),
    .remainder(div_rem),
    .last     (div_last)
  );

  // Sign-extend (or zero-extend) to 64 bits so one unsigned multiply covers both forms.
  assign a_ext  = sgn_q ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign b_ext  = sgn_q ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign prod_c = a_ext * b_ext;

  assign q_fix = q_neg_q ? XLEN'(-div_quo) : div_quo;
  assign r_fix = r_neg_q ? XLEN'(-div_rem) : div_rem;

  assign op_signed_c   = (Function_opcode == FUNCT_DIV);
  assign div_special_c = (Binput == '0) ||
                         (op_signed_c && (Ainput == INT_MIN) && (Binput == '1));

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    special_d = special_q;
    mcnt_d    = mcnt_q;
    load_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (Function_opcode)
            FUNCT_MTHI: hi_d = Ainput;
            FUNCT_MTLO: lo_d = Ainput;
            FUNCT_MULT, FUNCT_MULTU: begin
              a_d     = Ainput;
              b_d     = Binput;
              sgn_d   = (Function_opcode == FUNCT_MULT);
              mcnt_d  = MCNT_W'(1);
              state_d = ST_MUL;
            end
            FUNCT_DIV, FUNCT_DIVU: begin
              a_d       = Ainput;
              b_d       = Binput;
              sgn_d     = op_signed_c;
              q_neg_d   = op_signed_c && (Ainput[XLEN-1] ^ Binput[XLEN-1]);
              r_neg_d   = op_signed_c && Ainput[XLEN-1];
              special_d = div_special_c;
              load_c    = !div_special_c;
              state_d   = div_special_c ? ST_FIX : ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mcnt_q == MCNT_W'(MUL_CYCLES)) begin
          hi_d    = prod_c[2*XLEN-1:XLEN];
          lo_d    = prod_c[XLEN-1:0];
          state_d = ST_DONE;
        end else begin
          mcnt_d = mcnt_q + MCNT_W'(1);
        end
      end
      ST_DIV: if (div_last) state_d = ST_FIX;
      ST_FIX: begin
        // Special cases bypass the divider; everything else applies recorded signs.
        if (special_q) begin
          if (b_q == '0) begin
            lo_d = DIV_BY_ZERO_LO;
            hi_d = a_q;
          end else begin
            lo_d = INT_MIN;
            hi_d = '0;
          end
        end else begin
          lo_d = q_fix;
          hi_d = r_fix;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cancel_c && (state_q == ST_MUL || state_q == ST_DIV || state_q == ST_FIX)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      mcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      special_q <= special_d;
      mcnt_q    <= mcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer; covers cancel when MULDIV_CANCEL_EN is defined.
module tb_muldiv_sequencer;

  localparam int unsigned MUL_CYCLES = 2;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  Function_opcode = 6'h0;
  logic [31:0] Ainput = 32'h0;
  logic [31:0] Binput = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  muldiv_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .Function_opcode(Function_opcode),
    .Ainput         (Ainput),
    .Binput         (Binput),
`ifdef MULDIV_CANCEL_EN
    .cancel         (cancel),
`endif
    .busy           (busy),
    .done           (done),
    .hi             (hi),
    .lo             (lo)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] ua, ub, p;
    longint      sp;
    int          sa, sb, q, r;
    e.res = '0;
    e.lat = 0;
    case (op)
      6'h18: begin
        sp    = longint'($signed(a)) * longint'($signed(b));
        e.res = 64'(sp);
        e.lat = MUL_CYCLES;
      end
      6'h19: begin
        ua    = {32'h0, a};
        ub    = {32'h0, b};
        p     = ua * ub;
        e.res = p;
        e.lat = MUL_CYCLES;
      end
      default: begin
        if (b == 32'h0) begin
          e.res = {a, 32'hFFFF_FFFF};
          e.lat = 1;
        end else if (op == 6'h1A && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.res = {32'h0, 32'h8000_0000};
          e.lat = 1;
        end else if (op == 6'h1A) begin
          sa    = $signed(a);
          sb    = $signed(b);
          q     = sa / sb;
          r     = sa % sb;
          e.res = {32'(r), 32'(q)};
          e.lat = 33;
        end else begin
          e.res = {a % b, a / b};
          e.lat = 33;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one mult/div; count busy cycles until done, then pop and compare.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit intrude);
    exp_t e;
    int   nb, waited;
    sb_q.push_back(model(op, a, b));
    @(negedge clock);
    start = 1'b1; Function_opcode = op; Ainput = a; Binput = b;
    @(negedge clock);
    start = 1'b0; Ainput = $urandom; Binput = $urandom;
    nb = 0; waited = 0;
    while (!done && waited < 200) begin
      if (busy) nb++;
      if (intrude && waited == 5) begin
        start = 1'b1; Function_opcode = 6'h19;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      waited++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    check_eq("done_seen", 64'(done), 64'(1));
    check_eq("busy_cycles", 64'(nb), 64'(e.lat));
    check_eq("result_hilo", {hi, lo}, e.res);
    @(negedge clock);
    check_eq("done_pulse_width", 64'(done), 64'(0));
    check_eq("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic move_to(input logic [5:0] op, input logic [31:0] v);
    @(negedge clock);
    start = 1'b1; Function_opcode = op; Ainput = v;
    @(negedge clock);
    start = 1'b0;
    check_eq("mt_busy", 64'(busy), 64'(0));
  endtask

  // Start a normal divide and stop in its 10th iteration.
  task automatic start_div_to_iter10();
    @(negedge clock);
    start = 1'b1; Function_opcode = 6'h1A; Ainput = 32'd1000; Binput = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
  endtask

  task automatic expect_no_done(input string tag);
    int nd;
    nd = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) nd++;
    end
    check_eq(tag, 64'(nd), 64'(0));
  endtask

  logic [5:0] ops [4];

  initial begin
    ops = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    repeat (2) @(negedge clock);
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_done", 64'(done), 64'(0));
    check_eq("reset_hilo", {hi, lo}, 64'h0);
    reset = 1'b0;

    run_op(6'h18, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(6'h1B, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(6'h1B, 32'd5, 32'd0, 1'b0);
    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(6'h1A, 32'd100, 32'hFFFF_FFF9, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : $urandom;
      run_op(ops[i % 4], ra, rb, 1'b0);
    end

    move_to(6'h11, 32'h1234);
    check_eq("mthi_value", 64'(hi), 64'h1234);
    move_to(6'h13, 32'hABCD);
    check_eq("mtlo_value", {hi, lo}, {32'h1234, 32'hABCD});

    // Unknown funct must leave everything alone.
    @(negedge clock);
    start = 1'b1; Function_opcode = 6'h20; Ainput = 32'hDEAD;
    @(negedge clock);
    start = 1'b0;
    check_eq("unknown_busy", 64'(busy), 64'(0));
    check_eq("unknown_hilo", {hi, lo}, {32'h1234, 32'hABCD});

    start_div_to_iter10();
    check_eq("div_busy_mid", 64'(busy), 64'(1));
    check_eq("hilo_hold_busy", {hi, lo}, {32'h1234, 32'hABCD});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_done", 64'(done), 64'(0));
    check_eq("abort_hilo", {hi, lo}, 64'h0);
    expect_no_done("abort_no_done");

`ifdef MULDIV_CANCEL_EN
    move_to(6'h11, 32'h55);
    move_to(6'h13, 32'h66);
    start_div_to_iter10();
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check_eq("cancel_busy", 64'(busy), 64'(0));
    check_eq("cancel_hilo", {hi, lo}, {32'h55, 32'h66});
    expect_no_done("cancel_no_done");
    check_eq("cancel_hilo_after", {hi, lo}, {32'h55, 32'h66});
`endif

    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
